npu_load_ctrl: RTL and testbench
================================

Name: npu_load_ctrl

Overview:
- Sequencer between the host register interface (writedata, control_reg) and the NPU's image and weight SRAMs plus the compute engine.
- Streams the image as packed 32-bit words, then the conv filter/bias as bytes, into the SRAMs with generated addresses.
- On a RUN command it pulses compute start, waits for done, and exposes status.
- Instantiated inside mem_top, ahead of the SRAMs and NPU core.

Parameters:
IMG_WORDS, 224, number of 32-bit image beats (4 pixels per beat, MSB byte first)
WGT_BYTES, 18815, number of weight/bias byte beats
IMG_AW, 8, image SRAM word-address width
WGT_AW, 15, weight SRAM byte-address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
writedata  in  32  host data beat
control_reg  in  32  host command; only [1:0] decoded: 0=IDLE, 1=LOAD, 2=RUN, 3=CLEAR
img_we  out  1  image SRAM write enable
img_addr  out  IMG_AW  image SRAM word address
img_wdata  out  32  image SRAM write data (writedata unchanged)
wgt_we  out  1  weight SRAM write enable
wgt_addr  out  WGT_AW  weight SRAM byte address
wgt_wdata  out  8  weight SRAM write data (writedata[7:0])
npu_start  out  1  one-cycle compute start pulse
npu_done  in  1  compute-complete pulse/level from NPU core
status  out  32  [2:0]=state code, [3]=load_abort, [4]=run_err, [5]=done, rest 0

Behaviour:
- Async reset: state IDLE, counters 0; all outputs 0 (status 0).
- All outputs registered; SRAM write appears the cycle after the beat's clock edge (latency 1).
- Beat definition: every rising edge with cmd==LOAD while in IDLE, LOADED, DONE, LOAD_IMG or LOAD_WGT; no separate valid.
- States and codes: IDLE=0, LOAD_IMG=1, LOAD_WGT=2, LOADED=3, RUN=4, DONE=5.
- IDLE, LOADED or DONE, cmd==LOAD:
  - That beat is image beat 0; write img[0].
  - Clear load_abort, run_err and done.
  - Go to LOAD_IMG with img counter=1.
- LOAD_IMG: each beat writes img[count] = writedata and increments count.
  - Beat IMG_WORDS-1 moves to LOAD_WGT with wgt counter=0.
- LOAD_WGT: each beat writes wgt[count] = writedata[7:0].
  - Beat WGT_BYTES-1 moves to LOADED.
- LOADED: further LOAD beats are ignored; no writes and no restart until cmd leaves LOAD.
  - Restart needs cmd to pass through a non-LOAD value first; track with a last-cmd register.
  - The same edge rule applies to DONE.
- LOAD_IMG or LOAD_WGT, cmd!=LOAD: abort to IDLE, set load_abort (sticky), write nothing on that cycle.
- LOADED, cmd==RUN: npu_start=1 for exactly one cycle, enter RUN.
  - While RUN persists in LOADED/DONE, no second start; start is edge-triggered on entry to RUN.
- RUN, cmd==RUN received in IDLE or mid-load: ignored, set run_err.
- RUN: all commands ignored except CLEAR; npu_done goes to DONE and sets done.
  - npu_done on the same cycle as npu_start is honored (RUN lasts ≥1 cycle; done sampled from the cycle after start).
- DONE: cmd==RUN edge re-runs using the loaded data (new npu_start, back to RUN).
- CLEAR (cmd 3) in any state: go to IDLE, counters 0, sticky flags cleared.
- cmd 0 in LOADED or DONE: hold state; data is kept.
- Counter widths: exact IMG_AW/WGT_AW; terminal compares against parameter-1, so the counters never wrap.
- Reset mid-load or mid-run: immediate IDLE; SRAM contents untouched but considered invalid.

Decomposition:
- Shared package npu_pkg:
  - command codes CMD_IDLE/LOAD/RUN/CLEAR
  - state enum with the fixed codes above
  - status bit indices
  - default IMG_WORDS and WGT_BYTES
- One natural sub-module: npu_addr_gen.
  - Loadable counter with terminal flag, instantiated twice: image and weight.

Test Plan:
- Reset, then cmd=1 with 224 words 0x00010203+i, then 18815 bytes i[7:0] → img_we for 224 cycles, img_addr 0..223, img_wdata matches; wgt_we for 18815 cycles, wgt_addr 0..18814; status[2:0]=3.
- Three extra LOAD beats after load, then cmd=2 → no further writes; npu_start high exactly 1 cycle; status=4; npu_done pulse after 50 cycles → status[2:0]=5, status[5]=1.
- cmd=2 directly from IDLE → no npu_start; status[4]=1; state stays 0.
- cmd=1 for 100 image beats, then cmd=0 → writes stop at img_addr 99; status[3]=1, state 0; a new cmd=1 restarts at img_addr 0 and clears bit 3.
- Assert reset mid-weight load (beat 5000) → all outputs 0 immediately (asynchronous); after release, state 0.
- In DONE, toggle cmd 0→2 → second npu_start pulse, state 4; cmd=3 during RUN → state 0, status=0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared command codes, state encoding, status layout and default sizing
// for the NPU load/run sequencer.
package npu_pkg;

    localparam int unsigned IMG_WORDS_DEF = 224;
    localparam int unsigned WGT_BYTES_DEF = 18815;
    localparam int unsigned IMG_AW_DEF    = 8;
    localparam int unsigned WGT_AW_DEF    = 15;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned WGT_DW        = 8;
    localparam int unsigned STATUS_W      = 32;

    localparam int unsigned STAT_LOAD_ABORT = 3;
    localparam int unsigned STAT_RUN_ERR    = 4;
    localparam int unsigned STAT_DONE       = 5;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IMG = 3'd1,
        ST_LOAD_WGT = 3'd2,
        ST_LOADED   = 3'd3,
        ST_RUN      = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef struct packed {
        logic done;
        logic run_err;
        logic load_abort;
    } flags_t;

    function automatic logic [STATUS_W-1:0] pack_status(input state_e st, input flags_t fl);
        logic [STATUS_W-1:0] s;
        s                  = '0;
        s[2:0]             = st;
        s[STAT_LOAD_ABORT] = fl.load_abort;
        s[STAT_RUN_ERR]    = fl.run_err;
        s[STAT_DONE]       = fl.done;
        return s;
    endfunction

endpackage

// File: rtl/npu_addr_gen.sv
// Loadable SRAM address counter with a registered terminal-count flag.
module npu_addr_gen #(
    parameter int unsigned AW   = 8,
    parameter int unsigned LAST = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] count_o,
    output logic          last_o
);

    localparam logic [AW-1:0] LAST_V = AW'(LAST);

    logic [AW-1:0] count_q, count_d;
    logic          last_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            last_q  <= (LAST_V == '0);
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == LAST_V);
        end
    end

    assign count_o = count_q;
    assign last_o  = last_q;

endmodule

// File: rtl/npu_load_ctrl.sv
// Host-driven sequencer: streams image words and weight bytes into the NPU
// SRAMs, then launches the compute engine and reports status.
module npu_load_ctrl
    import npu_pkg::*;
#(
    parameter int unsigned IMG_WORDS = IMG_WORDS_DEF,
    parameter int unsigned WGT_BYTES = WGT_BYTES_DEF,
    parameter int unsigned IMG_AW    = IMG_AW_DEF,
    parameter int unsigned WGT_AW    = WGT_AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   control_reg,
    output logic                img_we,
    output logic [IMG_AW-1:0]   img_addr,
    output logic [DATA_W-1:0]   img_wdata,
    output logic                wgt_we,
    output logic [WGT_AW-1:0]   wgt_addr,
    output logic [WGT_DW-1:0]   wgt_wdata,
    output logic                npu_start,
    input  logic                npu_done,
    output logic [STATUS_W-1:0] status
);

    state_e                state_q, state_d;
    cmd_e                  cmd_last_q;
    flags_t                flags_q, flags_d;
    logic                  img_we_q, img_we_d;
    logic [IMG_AW-1:0]     img_addr_q, img_addr_d;
    logic [DATA_W-1:0]     img_wdata_q, img_wdata_d;
    logic                  wgt_we_q, wgt_we_d;
    logic [WGT_AW-1:0]     wgt_addr_q, wgt_addr_d;
    logic [WGT_DW-1:0]     wgt_wdata_q, wgt_wdata_d;
    logic                  npu_start_q, npu_start_d;
    logic [STATUS_W-1:0]   status_q, status_d;

    logic                  img_ld, img_inc, img_last;
    logic [IMG_AW-1:0]     img_ld_val, img_cnt;
    logic                  wgt_ld, wgt_inc, wgt_last;
    logic [WGT_AW-1:0]     wgt_cnt;
    logic                  start_load, start_run, abort;

    cmd_e                  cmd_c;
    logic                  is_load_c, load_edge_c, run_edge_c;
    logic                  ctrl_unused;

    assign cmd_c       = cmd_e'(control_reg[1:0]);
    assign ctrl_unused = ^control_reg[DATA_W-1:2];
    assign is_load_c   = (cmd_c == CMD_LOAD);
    // LOADED/DONE only react to a command that was not already held last cycle.
    assign load_edge_c = is_load_c && (cmd_last_q != CMD_LOAD);
    assign run_edge_c  = (cmd_c == CMD_RUN) && (cmd_last_q != CMD_RUN);

    npu_addr_gen #(.AW(IMG_AW), .LAST(IMG_WORDS - 1)) u_img_addr (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (img_ld),
        .load_val_i (img_ld_val),
        .inc_i      (img_inc),
        .count_o    (img_cnt),
        .last_o     (img_last)
    );

    npu_addr_gen #(.AW(WGT_AW), .LAST(WGT_BYTES - 1)) u_wgt_addr (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (wgt_ld),
        .load_val_i ('0),
        .inc_i      (wgt_inc),
        .count_o    (wgt_cnt),
        .last_o     (wgt_last)
    );

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        img_we_d    = 1'b0;
        img_addr_d  = img_addr_q;
        img_wdata_d = img_wdata_q;
        wgt_we_d    = 1'b0;
        wgt_addr_d  = wgt_addr_q;
        wgt_wdata_d = wgt_wdata_q;
        npu_start_d = 1'b0;
        img_ld      = 1'b0;
        img_ld_val  = '0;
        img_inc     = 1'b0;
        wgt_ld      = 1'b0;
        wgt_inc     = 1'b0;
        start_load  = 1'b0;
        start_run   = 1'b0;
        abort       = 1'b0;

        if (cmd_c == CMD_CLEAR) begin
            state_d = ST_IDLE;
            flags_d = '0;
            img_ld  = 1'b1;
            wgt_ld  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_load = is_load_c;
                    if (cmd_c == CMD_RUN) flags_d.run_err = 1'b1;
                end
                ST_LOADED, ST_DONE: begin
                    start_load = load_edge_c;
                    start_run  = run_edge_c;
                end
                ST_LOAD_IMG: begin
                    if (is_load_c) begin
                        img_we_d    = 1'b1;
                        img_addr_d  = img_cnt;
                        img_wdata_d = writedata;
                        if (img_last) begin
                            state_d = ST_LOAD_WGT;
                            img_ld  = 1'b1;
                            wgt_ld  = 1'b1;
                        end else begin
                            img_inc = 1'b1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
                ST_LOAD_WGT: begin
                    if (is_load_c) begin
                        wgt_we_d    = 1'b1;
                        wgt_addr_d  = wgt_cnt;
                        wgt_wdata_d = writedata[WGT_DW-1:0];
                        if (wgt_last) begin
                            state_d = ST_LOADED;
                            wgt_ld  = 1'b1;
                        end else begin
                            wgt_inc = 1'b1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (npu_done) begin
                        state_d      = ST_DONE;
                        flags_d.done = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Image beat 0 is written on the same edge that starts the load.
            if (start_load) begin
                state_d     = ST_LOAD_IMG;
                flags_d     = '0;
                img_we_d    = 1'b1;
                img_addr_d  = '0;
                img_wdata_d = writedata;
                img_ld      = 1'b1;
                img_ld_val  = IMG_AW'(1);
                wgt_ld      = 1'b1;
            end else if (start_run) begin
                state_d     = ST_RUN;
                npu_start_d = 1'b1;
            end

            if (abort) begin
                state_d            = ST_IDLE;
                flags_d.load_abort = 1'b1;
                if (cmd_c == CMD_RUN) flags_d.run_err = 1'b1;
                img_ld             = 1'b1;
                wgt_ld             = 1'b1;
            end
        end

        status_d = pack_status(state_d, flags_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_last_q  <= CMD_IDLE;
            flags_q     <= '0;
            img_we_q    <= 1'b0;
            img_addr_q  <= '0;
            img_wdata_q <= '0;
            wgt_we_q    <= 1'b0;
            wgt_addr_q  <= '0;
            wgt_wdata_q <= '0;
            npu_start_q <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_last_q  <= cmd_c;
            flags_q     <= flags_d;
            img_we_q    <= img_we_d;
            img_addr_q  <= img_addr_d;
            img_wdata_q <= img_wdata_d;
            wgt_we_q    <= wgt_we_d;
            wgt_addr_q  <= wgt_addr_d;
            wgt_wdata_q <= wgt_wdata_d;
            npu_start_q <= npu_start_d;
            status_q    <= status_d;
        end
    end

    assign img_we    = img_we_q;
    assign img_addr  = img_addr_q;
    assign img_wdata = img_wdata_q;
    assign wgt_we    = wgt_we_q;
    assign wgt_addr  = wgt_addr_q;
    assign wgt_wdata = wgt_wdata_q;
    assign npu_start = npu_start_q;
    assign status    = status_q;

endmodule

// File: tb/tb_npu_load_ctrl.sv
// Scoreboard bench for npu_load_ctrl: a command-level model queues expected
// SRAM writes and start pulses; a negedge monitor pops and compares them.
module tb_npu_load_ctrl;
    import npu_pkg::*;

    localparam int IMG = 224;
    localparam int WGT = 18815;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] control_reg;
    logic        img_we;
    logic [7:0]  img_addr;
    logic [31:0] img_wdata;
    logic        wgt_we;
    logic [14:0] wgt_addr;
    logic [7:0]  wgt_wdata;
    logic        npu_start;
    logic        npu_done;
    logic [31:0] status;

    npu_load_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .writedata   (writedata),
        .control_reg (control_reg),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_wdata   (img_wdata),
        .wgt_we      (wgt_we),
        .wgt_addr    (wgt_addr),
        .wgt_wdata   (wgt_wdata),
        .npu_start   (npu_start),
        .npu_done    (npu_done),
        .status      (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t img_exp[$];
    wr_t wgt_exp[$];
    int  start_exp;
    int  checks;
    int  errors;

    // Model: state code, position within the combined image+weight stream, flags, previous cmd.
    int  m_state, m_beat, m_last;
    bit  m_abort, m_runerr, m_done;

    task automatic model_reset();
        m_state = 0; m_beat = 0; m_last = 0;
        m_abort = 0; m_runerr = 0; m_done = 0;
    endtask

    task automatic push_beat(input logic [31:0] d);
        wr_t w;
        if (m_beat < IMG) begin
            w.addr = m_beat; w.data = d; img_exp.push_back(w);
        end else begin
            w.addr = m_beat - IMG; w.data = {24'h0, d[7:0]}; wgt_exp.push_back(w);
        end
        m_beat++;
        if (m_beat == IMG) m_state = 2;
        else if (m_beat == IMG + WGT) begin m_state = 3; m_beat = 0; end
    endtask

    task automatic begin_load(input logic [31:0] d);
        m_abort = 0; m_runerr = 0; m_done = 0;
        m_beat = 0; m_state = 1;
        push_beat(d);
    endtask

    task automatic model_step(input int cmd, input logic [31:0] d, input bit dn);
        bit le, re;
        le = (cmd == 1) && (m_last != 1);
        re = (cmd == 2) && (m_last != 2);
        if (cmd == 3) begin
            m_state = 0; m_beat = 0; m_abort = 0; m_runerr = 0; m_done = 0;
        end else begin
            case (m_state)
                0: if (cmd == 1) begin_load(d); else if (cmd == 2) m_runerr = 1;
                1, 2: begin
                    if (cmd == 1) push_beat(d);
                    else begin
                        m_state = 0; m_beat = 0; m_abort = 1;
                        if (cmd == 2) m_runerr = 1;
                    end
                end
                3, 5: begin
                    if (le) begin_load(d);
                    else if (re) begin start_exp++; m_state = 4; end
                end
                4: if (dn) begin m_state = 5; m_done = 1; end
                default: ;
            endcase
        end
        m_last = cmd;
    endtask

    function automatic logic [31:0] exp_status();
        logic [2:0] st;
        st = 3'(m_state);
        return {26'h0, m_done, m_runerr, m_abort, st};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare status after the edge.
    task automatic cyc(input int cmd, input logic [31:0] data, input bit dn);
        logic [31:0] r;
        logic [1:0]  c;
        r = $urandom();
        c = 2'(cmd);
        control_reg = {r[31:2], c};
        writedata   = data;
        npu_done    = dn;
        model_step(cmd, data, dn);
        @(posedge clk);
        #1;
        check_eq("status", status, exp_status());
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        #1;
        check_eq({name, "_img_left"}, 32'(img_exp.size()), 32'd0);
        check_eq({name, "_wgt_left"}, 32'(wgt_exp.size()), 32'd0);
        check_eq({name, "_start_left"}, 32'(start_exp), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_img_we"}, 32'(img_we), 32'd0);
        check_eq({name, "_img_addr"}, 32'(img_addr), 32'd0);
        check_eq({name, "_img_wdata"}, img_wdata, 32'd0);
        check_eq({name, "_wgt_we"}, 32'(wgt_we), 32'd0);
        check_eq({name, "_wgt_addr"}, 32'(wgt_addr), 32'd0);
        check_eq({name, "_wgt_wdata"}, 32'(wgt_wdata), 32'd0);
        check_eq({name, "_npu_start"}, 32'(npu_start), 32'd0);
        check_eq({name, "_status"}, status, 32'd0);
    endtask

    // Monitor: every write or start the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (img_we) begin
                checks++;
                if (img_exp.size() == 0) begin
                    errors++;
                    $display("FAIL img_write: unexpected addr %0d data %h", img_addr, img_wdata);
                end else begin
                    e = img_exp.pop_front();
                    if (int'(img_addr) != e.addr || img_wdata !== e.data) begin
                        errors++;
                        $display("FAIL img_write: got addr %0d data %h expected addr %0d data %h",
                                 img_addr, img_wdata, e.addr, e.data);
                    end
                end
            end
            if (wgt_we) begin
                checks++;
                if (wgt_exp.size() == 0) begin
                    errors++;
                    $display("FAIL wgt_write: unexpected addr %0d data %h", wgt_addr, wgt_wdata);
                end else begin
                    e = wgt_exp.pop_front();
                    if (int'(wgt_addr) != e.addr || wgt_wdata !== e.data[7:0]) begin
                        errors++;
                        $display("FAIL wgt_write: got addr %0d data %h expected addr %0d data %h",
                                 wgt_addr, wgt_wdata, e.addr, e.data[7:0]);
                    end
                end
            end
            if (npu_start) begin
                checks++;
                if (start_exp == 0) begin
                    errors++;
                    $display("FAIL npu_start: got unexpected pulse expected none at %0t", $time);
                end else begin
                    start_exp--;
                end
            end
        end
    end

    initial begin
        int dly;
        checks = 0; errors = 0; start_exp = 0;
        reset = 1'b1; control_reg = '0; writedata = '0; npu_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Full load with the counting pattern.
        for (int i = 0; i < IMG; i++) cyc(1, 32'h00010203 + 32'(i), 0);
        for (int i = 0; i < WGT; i++) cyc(1, 32'(i & 255), 0);
        check_eq("loaded_state", {29'h0, status[2:0]}, 32'd3);
        drain("load1");

        // Extra LOAD beats are ignored, then a single start and done after 50 cycles.
        for (int i = 0; i < 3; i++) cyc(1, $urandom(), 0);
        cyc(2, $urandom(), 0);
        check_eq("run_state", status, 32'h4);
        for (int i = 0; i < 50; i++) cyc(2, $urandom(), 0);
        cyc(2, $urandom(), 1);
        cyc(2, $urandom(), 0);
        check_eq("done_status", status, 32'h25);
        drain("run1");

        // RUN from IDLE only flags an error.
        cyc(3, 0, 0);
        for (int i = 0; i < 3; i++) cyc(2, $urandom(), 0);
        check_eq("run_from_idle", status, 32'h10);
        drain("runerr");

        // Abort after 100 image beats, then restart from address 0.
        for (int i = 0; i < 100; i++) cyc(1, $urandom(), 0);
        cyc(0, $urandom(), 0);
        check_eq("abort_status", status, 32'h8);
        drain("abort");
        cyc(1, $urandom(), 0);
        check_eq("restart_status", status, 32'h1);
        for (int i = 1; i < IMG; i++) cyc(1, $urandom(), 0);
        for (int i = 0; i <= 5000; i++) cyc(1, $urandom(), 0);

        // Asynchronous reset mid-weight load.
        #1 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        img_exp.delete(); wgt_exp.delete(); start_exp = 0;
        model_reset();
        control_reg = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0);
        check_eq("post_reset_status", status, 32'h0);

        // Fresh random load, run, rerun from DONE, done coincident with start, clear mid-run.
        for (int i = 0; i < IMG + WGT; i++) cyc(1, $urandom(), 0);
        drain("load2");
        cyc(0, 0, 0);
        cyc(2, 0, 0);
        dly = int'($urandom_range(1, 60));
        for (int i = 0; i < dly; i++) cyc(2, $urandom(), 0);
        cyc(2, 0, 1);
        for (int i = 0; i < 4; i++) cyc(2, 0, 0);
        cyc(0, 0, 0);
        cyc(2, 0, 0);
        cyc(2, 0, 1);
        check_eq("done_same_cycle", {29'h0, status[2:0]}, 32'd5);
        cyc(0, 0, 0);
        cyc(2, 0, 0);
        check_eq("rerun_state", {29'h0, status[2:0]}, 32'd4);
        for (int i = 0; i < 3; i++) cyc(2, 0, 0);
        cyc(3, 0, 0);
        check_eq("clear_in_run", status, 32'h0);
        drain("rerun");

        // Random command traffic, mostly LOAD with occasional aborts/clears.
        for (int i = 0; i < 2000; i++) begin
            int r, c;
            r = int'($urandom_range(0, 19));
            c = (r < 15) ? 1 : (r < 17) ? 0 : (r < 19) ? 2 : 3;
            cyc(c, $urandom(), bit'($urandom_range(0, 1)));
        end
        cyc(3, 0, 0);
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
